// File: rtl/mem_data_port.sv
// mem_data_port: memory-side responder for the load/store data request port.
// Serialises one 1/2/4-byte load or store into byte accesses on the 8-bit
// RAM bus (shared with instruction fetch via memGrant), reassembles loads
// little-endian and signals completion with a one-cycle LOutEn pulse.
// Optional build macro: MEM_IO_STALL_EN adds ioFull, which holds off stores
// whose latched address lies at or above IO_BASE.
module mem_data_port #(
    parameter int unsigned ADDR_W  = 32,
    parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dataEn,
    input  logic              LSRW,
    input  logic [ADDR_W-1:0] dataAddr,
    input  logic [1:0]        LSlen,
    input  logic [31:0]       Sdata,
    output logic              LSfree,
    output logic              LOutEn,
    output logic [31:0]       Ldata,
    input  logic              memGrant,
`ifdef MEM_IO_STALL_EN
    input  logic              ioFull,
`endif
    output logic              memReq,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RDLAST = 3'd2,
        ST_WR     = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] mem_a_r;
    logic [31:0]       data_sh_r;
    logic [2:0]        nbytes_r;
    logic [2:0]        k_r;
    logic              rd_pend_r;
    logic [31:0]       ldata_r;
    logic              lsfree_r;
    logic              loen_r;
    logic              memreq_r;

    logic              accept_s;
    logic              last_s;
    logic              rd_issue_s;
    logic              wr_issue_s;
    logic              io_addr_s;
    logic              io_full_s;
    logic              stall_s;
    logic [1:0]        cap_idx_s;

    // Access size code to byte count; the unused code 10 behaves as a word.
    function automatic logic [2:0] len_to_nbytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    assign accept_s   = (state_r == ST_IDLE) && dataEn;
    assign last_s     = (k_r == (nbytes_r - 3'd1));
    assign io_addr_s  = ({{32{1'b0}}, addr_r} >= {{ADDR_W{1'b0}}, IO_BASE});
`ifdef MEM_IO_STALL_EN
    assign io_full_s  = ioFull;
`else
    assign io_full_s  = 1'b0;
`endif
    assign stall_s    = io_addr_s && io_full_s;
    assign rd_issue_s = (state_r == ST_RD) && memGrant;
    assign wr_issue_s = (state_r == ST_WR) && memGrant && !stall_s;
    // k_r already counts the address issued last cycle, so its byte lane is k_r-1.
    assign cap_idx_s  = k_r[1:0] - 2'd1;

    // State register; a reset drops any request in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state: advance only on granted byte issues, finish through DONE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dataEn) begin
                    state_nxt_s = LSRW ? ST_WR : ST_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (rd_issue_s && last_s) begin
                    state_nxt_s = ST_RDLAST;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_RDLAST: begin
                state_nxt_s = ST_DONE;
            end
            ST_WR: begin
                if (wr_issue_s && last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WR;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Request latch plus byte walker: address/byte counter and store shifter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r    <= {ADDR_W{1'b0}};
            mem_a_r   <= {ADDR_W{1'b0}};
            data_sh_r <= 32'h0000_0000;
            nbytes_r  <= 3'd0;
            k_r       <= 3'd0;
        end else if (accept_s) begin
            addr_r    <= dataAddr;
            mem_a_r   <= dataAddr;
            data_sh_r <= Sdata;
            nbytes_r  <= len_to_nbytes(LSlen);
            k_r       <= 3'd0;
        end else if (rd_issue_s || wr_issue_s) begin
            // Address wraps naturally modulo 2^ADDR_W.
            mem_a_r <= mem_a_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            k_r     <= k_r + 3'd1;
            if (wr_issue_s) begin
                data_sh_r <= {8'h00, data_sh_r[31:8]};
            end
        end
    end

    // Load capture: RAM data arrives the cycle after its address, grant or not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend_r <= 1'b0;
            ldata_r   <= 32'h0000_0000;
        end else begin
            rd_pend_r <= rd_issue_s;
            if (accept_s) begin
                ldata_r <= 32'h0000_0000;
            end else if (rd_pend_r) begin
                ldata_r[{cap_idx_s, 3'b000} +: 8] <= mem_din;
            end
        end
    end

    // Handshake outputs registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lsfree_r <= 1'b1;
            loen_r   <= 1'b0;
            memreq_r <= 1'b0;
        end else begin
            lsfree_r <= (state_nxt_s == ST_IDLE);
            loen_r   <= (state_nxt_s == ST_DONE);
            memreq_r <= (state_nxt_s == ST_RD) || (state_nxt_s == ST_WR);
        end
    end

    assign LSfree   = lsfree_r;
    assign LOutEn   = loen_r;
    assign Ldata    = ldata_r;
    assign memReq   = memreq_r;
    assign mem_a    = mem_a_r;
    assign mem_dout = data_sh_r[7:0];
    // The write strobe must follow this cycle's grant, so it is decoded live.
    assign mem_wr   = wr_issue_s;

endmodule

// File: tb/tb_mem_data_port.sv
// Bench for mem_data_port: a transaction-level model (bytes left to issue,
// tail cycles to the completion pulse, expected load word from a RAM array)
// checked every cycle, plus hand-computed literals per directed request.
`timescale 1ns/1ps
module tb_mem_data_port;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        dataEn = 1'b0;
    logic        LSRW = 1'b0;
    logic [31:0] dataAddr = 32'h0;
    logic [1:0]  LSlen = 2'b00;
    logic [31:0] Sdata = 32'h0;
    logic        LSfree;
    logic        LOutEn;
    logic [31:0] Ldata;
    logic        memGrant = 1'b0;
    logic        memReq;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = 8'h00;
`ifdef MEM_IO_STALL_EN
    logic        ioFull = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  ram [logic [31:0]];
    logic [31:0] seen_a [$];
    logic [7:0]  seen_d [$];

    // model state
    logic        m_busy = 1'b0;
    logic        m_write = 1'b0;
    logic [31:0] m_base = 32'h0;
    logic [31:0] m_sdata = 32'h0;
    logic [31:0] m_result = 32'h0;
    logic [31:0] m_hold = 32'h0;
    int          m_n = 0;
    int          m_k = 0;
    int          m_tail = 0;

    mem_data_port dut (
        .clk(clk), .rst(rst), .dataEn(dataEn), .LSRW(LSRW), .dataAddr(dataAddr),
        .LSlen(LSlen), .Sdata(Sdata), .LSfree(LSfree), .LOutEn(LOutEn), .Ldata(Ldata),
        .memGrant(memGrant),
`ifdef MEM_IO_STALL_EN
        .ioFull(ioFull),
`endif
        .memReq(memReq), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
        .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    // RAM read port: address seen in one cycle, data presented the next.
    initial begin : ram_port
        logic [31:0] rd_a;
        forever begin
            @(negedge clk);
            rd_a = mem_a;
            @(posedge clk);
            #1;
            mem_din = ram_rd(rd_a);
        end
    end

    // Per-cycle comparison against the transaction model.
    initial begin : compare
        logic stall;
        logic issue;
        logic pulse;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_busy = 1'b0; m_hold = 32'h0; m_k = 0; m_n = 0; m_tail = 0;
                check("rst_lsfree", 32'(LSfree), 32'd1);
                check("rst_loen",   32'(LOutEn), 32'd0);
                check("rst_ldata",  Ldata, 32'd0);
                check("rst_memreq", 32'(memReq), 32'd0);
                check("rst_mem_a",  mem_a, 32'd0);
                check("rst_mem_wr", 32'(mem_wr), 32'd0);
                check("rst_dout",   32'(mem_dout), 32'd0);
            end else begin
                stall = 1'b0;
`ifdef MEM_IO_STALL_EN
                stall = m_write && (m_base >= 32'h0003_0000) && ioFull;
`endif
                issue = m_busy && (m_k < m_n) && memGrant && !stall;
                pulse = m_busy && (m_k == m_n) && (m_tail == 0);
                check("lsfree", 32'(LSfree), 32'(!m_busy));
                check("memreq", 32'(memReq), 32'(m_busy && (m_k < m_n)));
                check("mem_wr", 32'(mem_wr), 32'(issue && m_write));
                check("loen",   32'(LOutEn), 32'(pulse));
                if (issue) begin
                    check("mem_a", mem_a, m_base + 32'(m_k));
                    seen_a.push_back(mem_a);
                    if (m_write) begin
                        check("dout", 32'(mem_dout), (m_sdata >> (8 * m_k)) & 32'hFF);
                        seen_d.push_back(mem_dout);
                    end
                end
                if (pulse) check("ldata", Ldata, m_result);
                else if (!m_busy) check("ldata_hold", Ldata, m_hold);
                // advance the model to the next cycle
                if (!m_busy) begin
                    if (dataEn) begin
                        m_busy = 1'b1; m_write = LSRW; m_base = dataAddr; m_sdata = Sdata;
                        m_n = (LSlen == 2'b00) ? 1 : ((LSlen == 2'b01) ? 2 : 4);
                        m_k = 0; m_tail = 0; m_result = 32'h0;
                        if (!LSRW) begin
                            for (int i = 0; i < m_n; i++)
                                m_result |= 32'(ram_rd(m_base + 32'(i))) << (8 * i);
                        end
                    end
                end else if (issue) begin
                    m_k++;
                    if (m_k == m_n) m_tail = m_write ? 0 : 1;
                end else if (pulse) begin
                    m_busy = 1'b0;
                    m_hold = m_result;
                end else if (m_k == m_n) begin
                    m_tail--;
                end
            end
        end
    end

    // One request from acceptance to completion; lat counts cycles after accept.
    task automatic run_req(input logic w, input logic [31:0] a, input logic [1:0] len,
                           input logic [31:0] sd, input logic [31:0] gmask,
                           input logic [31:0] imask, output int lat, output logic [31:0] ld);
        @(posedge clk);
        #1;
        dataEn = 1'b1; LSRW = w; dataAddr = a; LSlen = len; Sdata = sd; memGrant = 1'b0;
`ifdef MEM_IO_STALL_EN
        ioFull = 1'b0;
`endif
        seen_a.delete();
        seen_d.delete();
        lat = -1;
        ld = 32'h0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            dataEn = 1'b0;
            memGrant = (c < 32) ? gmask[c] : 1'b1;
`ifdef MEM_IO_STALL_EN
            ioFull = (c < 32) ? imask[c] : 1'b0;
`endif
            @(negedge clk);
            if (LOutEn) begin
                lat = c;
                ld = Ldata;
            end
        end
`ifdef MEM_IO_STALL_EN
        ioFull = 1'b0;
`endif
        if (lat < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL timeout: no LOutEn for request at %h within 40 cycles", a);
        end
        if (imask == 32'hFFFF_FFFF) lat = lat; // imask is only consumed by the IO build
    endtask

    initial begin : stim
        int lat;
        int pulses;
        logic [31:0] ld;
        ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
        ram[32'h7] = 8'hEF;   ram[32'h8] = 8'hBE;
        ram[32'h30000] = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // word load, grant held
        run_req(1'b0, 32'h100, 2'b11, 32'h0, 32'hFFFF_FFFF, 32'h0, lat, ld);
        check("wl_lat", 32'(lat), 32'd6);
        check("wl_data", ld, 32'h4433_2211);
        check("wl_n", 32'(seen_a.size()), 32'd4);
        if (seen_a.size() == 4) begin
            check("wl_a0", seen_a[0], 32'h100); check("wl_a3", seen_a[3], 32'h103);
        end

        // byte store
        run_req(1'b1, 32'h2001, 2'b00, 32'hAABB_CCDD, 32'hFFFF_FFFF, 32'h0, lat, ld);
        check("bs_lat", 32'(lat), 32'd2);
        check("bs_data", ld, 32'h0);
        check("bs_n", 32'(seen_a.size()), 32'd1);
        if (seen_a.size() == 1) begin
            check("bs_a", seen_a[0], 32'h2001); check("bs_d", 32'(seen_d[0]), 32'hDD);
        end

        // half load with grant dropped for two cycles between bytes
        run_req(1'b0, 32'h7, 2'b01, 32'h0, 32'hFFFF_FFF3, 32'h0, lat, ld);
        check("hl_lat", 32'(lat), 32'd6);
        check("hl_data", ld, 32'h0000_BEEF);
        check("hl_n", 32'(seen_a.size()), 32'd2);
        if (seen_a.size() == 2) check("hl_a1", seen_a[1], 32'h8);

        // word store wrapping the address space
        run_req(1'b1, 32'hFFFF_FFFE, 2'b11, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, lat, ld);
        check("ws_lat", 32'(lat), 32'd5);
        check("ws_n", 32'(seen_a.size()), 32'd4);
        if (seen_a.size() == 4) begin
            check("ws_a0", seen_a[0], 32'hFFFF_FFFE); check("ws_a1", seen_a[1], 32'hFFFF_FFFF);
            check("ws_a2", seen_a[2], 32'h0);         check("ws_a3", seen_a[3], 32'h1);
            check("ws_d3", 32'(seen_d[3]), 32'h12);
        end

        // LSlen 10 acts as a word, misaligned; 0x104 is unwritten RAM
        run_req(1'b0, 32'h101, 2'b10, 32'h0, 32'hFFFF_FFFF, 32'h0, lat, ld);
        check("l10_lat", 32'(lat), 32'd6);
        check("l10_data", ld, 32'h0044_3322);

        // misaligned half store with grant gaps
        run_req(1'b1, 32'h3, 2'b01, 32'h0000_A1B2, 32'hFFFF_FFF5, 32'h0, lat, ld);
        check("hs_lat", 32'(lat), 32'd5);
        if (seen_d.size() == 2) check("hs_d1", 32'(seen_d[1]), 32'hA1);

        // byte load: upper bytes stay zero
        run_req(1'b0, 32'h102, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'h0, lat, ld);
        check("bl_lat", 32'(lat), 32'd3);
        check("bl_data", ld, 32'h0000_0033);

        // reset during a word load
        @(posedge clk);
        #1;
        dataEn = 1'b1; LSRW = 1'b0; dataAddr = 32'h100; LSlen = 2'b11; memGrant = 1'b1;
        @(posedge clk);
        #1;
        dataEn = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mr_lsfree", 32'(LSfree), 32'd1);
        check("mr_mem_wr", 32'(mem_wr), 32'd0);
        check("mr_memreq", 32'(memReq), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        memGrant = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (LOutEn) pulses++;
        end
        check("mr_no_pulse", 32'(pulses), 32'd0);

        // recovery after reset
        run_req(1'b0, 32'h100, 2'b11, 32'h0, 32'hFFFF_FFFF, 32'h0, lat, ld);
        check("rc_lat", 32'(lat), 32'd6);
        check("rc_data", ld, 32'h4433_2211);

`ifdef MEM_IO_STALL_EN
        // IO store held off by ioFull for three cycles
        run_req(1'b1, 32'h30004, 2'b00, 32'h0000_0077, 32'hFFFF_FFFF, 32'h0000_000E, lat, ld);
        check("io_lat", 32'(lat), 32'd5);
        check("io_n", 32'(seen_a.size()), 32'd1);
        // non-IO store ignores ioFull
        run_req(1'b1, 32'h100, 2'b00, 32'h0000_0099, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, ld);
        check("nio_lat", 32'(lat), 32'd2);
        // IO load ignores ioFull
        run_req(1'b0, 32'h30000, 2'b00, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, ld);
        check("iol_lat", 32'(lat), 32'd3);
        check("iol_data", ld, 32'h0000_005A);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_data_port.md
Name: mem_data_port

Overview:
- Memory-side responder for the load/store unit's data request interface.
- Accepts one load or store request (address, length, store data) and serialises it into 1–4 byte accesses on the 8-bit RAM bus.
- For loads, reassembles the bytes little-endian and returns them with a one-cycle completion pulse; stores get the same pulse as an acknowledgement.
- Sits inside the memory controller, beside the instruction-fetch port, and shares the RAM bus through a grant from the arbiter.

Parameters:
ADDR_W, 32, width of dataAddr and mem_a
IO_BASE, 32'h30000, lowest address of the memory-mapped IO region (used only by the optional feature)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active low
dataEn  input  1  request valid from LS unit
LSRW  input  1  0 = load, 1 = store
dataAddr  input  ADDR_W  byte address of first byte
LSlen  input  2  access size minus one: 00 byte, 01 half, 11 word (10 treated as 11)
Sdata  input  32  store data; byte k = Sdata[8k+7:8k]
LSfree  output  1  port idle, request may be presented
LOutEn  output  1  one-cycle completion pulse
Ldata  output  32  load result, zero-extended; valid while LOutEn is high
memGrant  input  1  arbiter grants the RAM bus this cycle
memReq  output  1  port wants the RAM bus (high in RD/WR states)
mem_a  output  ADDR_W  RAM byte address
mem_wr  output  1  RAM write strobe
mem_dout  output  8  RAM write data
mem_din  input  8  RAM read data; 1-cycle latency after address

Behaviour:
- Reset (rst low, asynchronous), all outputs forced to these values: LSfree=1, LOutEn=0, Ldata=0, memReq=0, mem_a=0, mem_wr=0, mem_dout=0; state IDLE; byte counters cleared.
- A request in flight when reset asserts is dropped. No completion pulse is issued for it.
- States: IDLE, RD, RDLAST, WR, DONE.
- IDLE:
  - LSfree=1.
  - On dataEn=1, latch addr, len, Sdata and RW; set nbytes = LSlen+1 (LSlen 10 gives 4); go to RD or WR.
  - LSfree drops to 0 the next cycle. dataEn is ignored in every state except IDLE.
- WR:
  - Each cycle with memGrant=1: mem_a = addr+k, mem_dout = byte k, mem_wr=1, then k++.
  - After byte nbytes-1 is written, go to DONE.
  - Cycles with memGrant=0: mem_wr=0 and k holds.
- RD:
  - Each cycle with memGrant=1: mem_a = addr+k, mem_wr=0, k++.
  - In the cycle after each issued address, capture mem_din into Ldata byte (k-1) unconditionally, whether or not grant is held.
  - After the last address issues, go to RDLAST. RDLAST captures the final byte and goes to DONE.
  - Bytes above nbytes remain 0.
- DONE: LOutEn=1 for exactly one cycle, LSfree=0, next state IDLE.
  - For stores, Ldata=0 in DONE.
  - Ldata holds its value until the next request is accepted.
- Latency with grant held continuously: store of n bytes pulses LOutEn n+1 cycles after acceptance; load pulses n+2 cycles after acceptance.
- Address arithmetic: addr+k wraps modulo 2^ADDR_W. No alignment check; misaligned accesses are legal and simply serialised.
- memReq is high only in RD and WR; the arbiter may drop memGrant on any cycle.
- Back-to-back requests: the earliest acceptance of a new request is the cycle after DONE.

Optional Feature:
- Macro: MEM_IO_STALL_EN.
- When defined:
  - Adds input ioFull (1 bit).
  - In WR, if the latched addr >= IO_BASE and ioFull=1, the byte is not issued (mem_wr=0, k holds) even when memGrant=1.
  - Reads to IO addresses are unaffected.
- When undefined: the ioFull port does not exist and writes depend only on memGrant.

Test Plan:
- Reset mid-load: assert rst low during RD of a word load → LSfree=1, LOutEn never pulses, mem_wr=0 immediately.
- Word load at 0x100, RAM bytes 11,22,33,44, grant held → mem_a 0x100..0x103 on consecutive cycles; LOutEn 6 cycles after accept with Ldata=0x44332211.
- Byte store at 0x2001 with Sdata=0xAABBCCDD, LSlen=00 → single cycle with mem_wr=1, mem_a=0x2001, mem_dout=0xDD; LOutEn 2 cycles after accept; Ldata=0.
- Half load at 0x7 with memGrant low for 2 cycles between bytes → both bytes captured correctly (e.g. 0xBEEF); LOutEn delayed by exactly 2 cycles; mem_a never skips 0x8.
- Word store at 0xFFFFFFFE → mem_a sequence FFFFFFFE, FFFFFFFF, 0, 1 (wrap-around).
- MEM_IO_STALL_EN: byte store to 0x30004 with ioFull=1 for 3 cycles, then 0 → no mem_wr while ioFull=1; single write once ioFull drops; LOutEn the following cycle.
